// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_if
// Purpose  : Bundles the BIOS (B) and CPU (C) request ports plus the RAM macro
//            pins shared through ram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
);
    logic                  i_booted;

    logic                  i_b_req;
    logic                  i_b_we;
    logic [ADDR_WIDTH:0]   i_b_addr;
    logic [DATA_WIDTH:0]   i_b_wdata;
    logic [3:0]            i_b_be;
    logic                  o_b_gnt;
    logic                  o_b_rvalid;

    logic                  i_c_req;
    logic                  i_c_we;
    logic [ADDR_WIDTH:0]   i_c_addr;
    logic [DATA_WIDTH:0]   i_c_wdata;
    logic [3:0]            i_c_be;
    logic                  o_c_gnt;
    logic                  o_c_rvalid;

    logic [DATA_WIDTH:0]   o_rdata;

    logic                  o_ram_en;
    logic                  o_ram_we;
    logic [3:0]            o_ram_be;
    logic [ADDR_WIDTH:0]   o_ram_addr;
    logic [DATA_WIDTH:0]   o_ram_wdata;
    logic [DATA_WIDTH:0]   i_ram_rdata;

    // Arbiter side
    modport slave (
        input  i_booted,
        input  i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_be,
        output o_b_gnt, o_b_rvalid,
        input  i_c_req, i_c_we, i_c_addr, i_c_wdata, i_c_be,
        output o_c_gnt, o_c_rvalid,
        output o_rdata,
        output o_ram_en, o_ram_we, o_ram_be, o_ram_addr, o_ram_wdata,
        input  i_ram_rdata
    );

    // Requester / RAM-model side
    modport master (
        output i_booted,
        output i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_be,
        input  o_b_gnt, o_b_rvalid,
        output i_c_req, i_c_we, i_c_addr, i_c_wdata, i_c_be,
        input  o_c_gnt, o_c_rvalid,
        input  o_rdata,
        input  o_ram_en, o_ram_we, o_ram_be, o_ram_addr, o_ram_wdata,
        output i_ram_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Round-robin arbiter sharing a single-port, 1-cycle-latency RAM
//            between the BIOS loader (B) and the CPU data port (C).
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ram_port_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_owner;   // 0 = B, 1 = C
    logic                r_resp_owner;
    logic [DATA_WIDTH:0] r_rdata;

    logic                w_eff_b;
    logic                w_eff_c;
    logic                w_issue;
    logic                w_win_c;
    logic                w_win_we;
    logic                w_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
            r_resp_owner <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_last_owner <= w_win_c;
                if (!w_win_we) begin
                    r_resp_owner <= w_win_c;
                end
            end
            if (w_resp) begin
                r_rdata <= bus.i_ram_rdata;
            end
        end
    end

    // Reset masks requests and the response strobe so nothing leaks out in the reset cycle
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_win_c     = 1'b0;
        w_resp      = 1'b0;
        w_eff_b     = bus.i_b_req & ~rst;
        w_eff_c     = bus.i_c_req & bus.i_booted & ~rst;
        w_win_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_eff_b || w_eff_c) begin
                    w_issue  = 1'b1;
                    w_win_c  = w_eff_c & (~w_eff_b | ~r_last_owner);
                    w_win_we = w_win_c ? bus.i_c_we : bus.i_b_we;
                    if (!w_win_we) begin
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_RESP: begin
                w_resp      = ~rst;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.o_ram_en    = w_issue;
    assign bus.o_ram_we    = w_issue & w_win_we;
    assign bus.o_ram_be    = (w_issue & w_win_we) ? (w_win_c ? bus.i_c_be : bus.i_b_be) : 4'b0000;
    assign bus.o_ram_addr  = (w_issue & w_win_c) ? bus.i_c_addr  : bus.i_b_addr;
    assign bus.o_ram_wdata = (w_issue & w_win_c) ? bus.i_c_wdata : bus.i_b_wdata;

    assign bus.o_b_gnt     = w_issue & ~w_win_c;
    assign bus.o_c_gnt     = w_issue &  w_win_c;

    assign bus.o_b_rvalid  = w_resp & ~r_resp_owner;
    assign bus.o_c_rvalid  = w_resp &  r_resp_owner;
    assign bus.o_rdata     = w_resp ? bus.i_ram_rdata : r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Scoreboard bench for ram_port_arbiter with a 1-cycle RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    typedef struct {
        bit          is_rd;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;

    exp_t q_exp [2][$];
    int   log_p [$];
    int   log_c [$];

    logic [31:0] mem [0:255];

    ram_port_arbiter_if #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) ifc ();

    ram_port_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ifc.o_ram_en) begin
            if (ifc.o_ram_we) begin
                for (int i = 0; i < 4; i++)
                    if (ifc.o_ram_be[i]) mem[ifc.o_ram_addr[7:0]][8*i +: 8] <= ifc.o_ram_wdata[8*i +: 8];
            end else begin
                ifc.i_ram_rdata <= mem[ifc.o_ram_addr[7:0]];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the per-port scoreboard on every gnt / rvalid pulse
    always @(negedge clk) begin
        logic g;
        logic v;
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            g = (p == 1) ? ifc.o_c_gnt    : ifc.o_b_gnt;
            v = (p == 1) ? ifc.o_c_rvalid : ifc.o_b_rvalid;
            if (g) begin
                log_p.push_back(p);
                log_c.push_back(cyc);
                if (q_exp[p].size() == 0 || q_exp[p][0].is_rd) begin
                    check((p == 1) ? "unexpected_c_gnt" : "unexpected_b_gnt", 64'd1, 64'd0);
                end else begin
                    e = q_exp[p].pop_front();
                    check("gnt_ram_en",   {63'd0, ifc.o_ram_en}, 64'd1);
                    check("gnt_ram_we",   {63'd0, ifc.o_ram_we}, {63'd0, e.we});
                    check("gnt_ram_addr", {32'd0, ifc.o_ram_addr}, {32'd0, e.addr});
                    check("gnt_ram_be",   {60'd0, ifc.o_ram_be}, {60'd0, e.be});
                    if (e.we) check("gnt_ram_wdata", {32'd0, ifc.o_ram_wdata}, {32'd0, e.wdata});
                end
            end
            if (v) begin
                if (q_exp[p].size() == 0 || !q_exp[p][0].is_rd) begin
                    check((p == 1) ? "unexpected_c_rvalid" : "unexpected_b_rvalid", 64'd1, 64'd0);
                end else begin
                    e = q_exp[p].pop_front();
                    check((p == 1) ? "c_rdata" : "b_rdata", {32'd0, ifc.o_rdata}, {32'd0, e.rdata});
                end
            end
        end
    end

    task automatic push_exp(input int p, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] rdata);
        exp_t e;
        e.is_rd = 1'b0; e.we = we; e.addr = addr; e.wdata = wdata;
        e.be = we ? be : 4'b0000; e.rdata = 32'd0;
        q_exp[p].push_back(e);
        if (!we) begin
            e.is_rd = 1'b1; e.rdata = rdata;
            q_exp[p].push_back(e);
        end
    endtask

    task automatic set_port(input int p, input bit req, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        if (p == 0) begin
            ifc.i_b_req = req; ifc.i_b_we = we; ifc.i_b_addr = addr; ifc.i_b_wdata = wdata; ifc.i_b_be = be;
        end else begin
            ifc.i_c_req = req; ifc.i_c_we = we; ifc.i_c_addr = addr; ifc.i_c_wdata = wdata; ifc.i_c_be = be;
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the grant with req dropped
    task automatic do_req(input int p, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] rdata);
        int t;
        push_exp(p, we, addr, wdata, be, rdata);
        set_port(p, 1'b1, we, addr, wdata, be);
        t = 0;
        @(negedge clk);
        while (!((p == 1) ? ifc.o_c_gnt : ifc.o_b_gnt)) begin
            t++;
            if (t > 50) begin
                check((p == 1) ? "c_gnt_timeout" : "b_gnt_timeout", 64'd0, 64'd1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        if (p == 0) ifc.i_b_req = 1'b0; else ifc.i_c_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_log();
        log_p.delete();
        log_c.delete();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        ifc.i_booted = 1'b1;
        ifc.i_ram_rdata = 32'd0;
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_port(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {58'd0, ifc.o_ram_en, ifc.o_ram_we, ifc.o_b_gnt, ifc.o_c_gnt,
                                ifc.o_b_rvalid, ifc.o_c_rvalid}, 64'd0);
        check("reset_be_rdata", {28'd0, ifc.o_ram_be, ifc.o_rdata}, 64'd0);
        @(posedge clk); #1;

        // B write, then B read-back, then partial-lane write
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0);
        @(negedge clk);
        check("after_write_idle", {62'd0, ifc.o_b_rvalid, ifc.o_ram_en}, 64'd0);
        @(posedge clk); #1;
        do_req(0, 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check("resp_cycle_b", {62'd0, ifc.o_ram_en, ifc.o_b_rvalid}, 64'd1);
        @(posedge clk); #1;
        do_req(0, 1'b1, 32'h10, 32'h11223344, 4'b0011, 32'd0);

        // C gated by boot flag, then granted the cycle it rises
        ifc.i_booted = 1'b0;
        push_exp(1, 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD3344);
        set_port(1, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("unbooted_c_blocked", {62'd0, ifc.o_c_gnt, ifc.o_ram_en}, 64'd0);
        end
        @(posedge clk); #1 ifc.i_booted = 1'b1;
        @(negedge clk);
        check("booted_c_gnt", {63'd0, ifc.o_c_gnt}, 64'd1);
        @(posedge clk); #1 ifc.i_c_req = 1'b0;
        @(negedge clk);
        check("resp_cycle_c", {63'd0, ifc.o_c_rvalid}, 64'd1);
        @(posedge clk); #1;

        // Continuous writes from both ports right after reset
        do_reset();
        clear_log();
        fork
            for (int i = 0; i < 4; i++) do_req(0, 1'b1, 32'h20 + i, 32'hB0000000 + i, 4'hF, 32'd0);
            for (int i = 0; i < 4; i++) do_req(1, 1'b1, 32'h30 + i, 32'hC0000000 + i, 4'hF, 32'd0);
        join
        check("rr_grant_count", 64'(log_p.size()), 64'd8);
        if (log_p.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("rr_grant_port", 64'(log_p[i]), 64'(i % 2));
                if (i > 0) check("rr_grant_spacing", 64'(log_c[i] - log_c[i-1]), 64'd1);
            end
        end

        // B read and C write pending together
        clear_log();
        fork
            do_req(0, 1'b0, 32'h21, 32'd0, 4'hF, 32'hB0000001);
            do_req(1, 1'b1, 32'h40, 32'h12345678, 4'b1100, 32'd0);
        join
        check("rd_wr_grant_count", 64'(log_p.size()), 64'd2);
        if (log_p.size() == 2) begin
            check("rd_wr_first_b", 64'(log_p[0]), 64'd0);
            check("rd_wr_second_c", 64'(log_p[1]), 64'd1);
            check("rd_wr_spacing", 64'(log_c[1] - log_c[0]), 64'd2);
        end
        do_req(1, 1'b0, 32'h40, 32'd0, 4'hF, 32'h12340000);
        @(negedge clk);
        @(posedge clk); #1;

        // Reset lands on the RESP cycle of a C read
        q_exp[1].push_back('{is_rd: 1'b0, we: 1'b0, addr: 32'h31, wdata: 32'd0, be: 4'b0000, rdata: 32'd0});
        set_port(1, 1'b1, 1'b0, 32'h31, 32'd0, 4'hF);
        @(negedge clk);
        check("pre_reset_c_gnt", {63'd0, ifc.o_c_gnt}, 64'd1);
        @(posedge clk); #1;
        ifc.i_c_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("reset_in_resp_no_rvalid", {62'd0, ifc.o_c_rvalid, ifc.o_b_rvalid}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_no_rvalid", {62'd0, ifc.o_c_rvalid, ifc.o_ram_en}, 64'd0);
        @(posedge clk); #1;
        clear_log();
        fork
            do_req(0, 1'b1, 32'h50, 32'h55555555, 4'hF, 32'd0);
            do_req(1, 1'b1, 32'h51, 32'hAAAAAAAA, 4'hF, 32'd0);
        join
        check("post_reset_grant_count", 64'(log_p.size()), 64'd2);
        if (log_p.size() == 2) check("post_reset_b_first", 64'(log_p[0]), 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_b_empty", 64'(q_exp[0].size()), 64'd0);
        check("scoreboard_c_empty", 64'(q_exp[1].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
